// File: rtl/bus_fabric.sv
// bus_fabric: 6502 address decoder, read-data multiplexer and wait-state
// stall generator for the Apple-1 top level.
//
// Optional feature macro: BUS_FAULT_EN. When defined, a fault counter,
// first-fault address latch, 4-byte status window at STAT_BASE and the
// fault output are built. When undefined, STAT_BASE decodes as unmapped
// and fault is tied low.
//
// Ports:
//   clk25      in   25 MHz master clock
//   rst_n      in   asynchronous active-low reset
//   cpu_clken  in   CPU clock-enable strobe
//   cpu_ab     in   CPU address [15:0]
//   cpu_we     in   CPU write
//   cpu_dbo    in   CPU write data [7:0] (no register here stores its value)
//   cpu_dbi    out  read data to the CPU [7:0], combinational
//   cpu_ready  out  low stalls the CPU
//   slv_cs     out  one-hot chip selects [NSLV-1:0]
//   slv_we     out  level write strobes [NSLV-1:0]
//   slv_en     out  access-completion strobes [NSLV-1:0]
//   slv_dout   in   packed slave read data [8*NSLV-1:0]
//   fault      out  fault count is nonzero
`timescale 1ns/1ps
module bus_fabric #(
  parameter int                 NSLV      = 6,
  parameter logic [16*NSLV-1:0] SLV_BASE  = {16'hFF00, 16'hE000, 16'hD012, 16'hD010, 16'hC000, 16'h0000},
  parameter logic [16*NSLV-1:0] SLV_MASK  = {16'hFF00, 16'hF000, 16'hFFFE, 16'hFFFE, 16'hFFFC, 16'hE000},
  parameter logic [4*NSLV-1:0]  SLV_WAIT  = {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0},
  parameter logic [7:0]         FILL      = 8'hFF,
  parameter logic [15:0]        STAT_BASE = 16'hC010
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              cpu_clken,
  input  logic [15:0]       cpu_ab,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_dbo,
  output logic [7:0]        cpu_dbi,
  output logic              cpu_ready,
  output logic [NSLV-1:0]   slv_cs,
  output logic [NSLV-1:0]   slv_we,
  output logic [NSLV-1:0]   slv_en,
  input  logic [8*NSLV-1:0] slv_dout,
  output logic              fault
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  logic [NSLV-1:0] hitv_s;
  logic [NSLV-1:0] cs_s;
  logic            stat_hit_s;
  logic [3:0]      k_s;
  logic [7:0]      slv_rd_s;
  logic [7:0]      stat_rd_s;
  logic            ready_s;
  logic            idle_eval_s;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NSLV-1:0] wsel_q, wsel_d;

  // The write data is only ever a trigger for the clear, never stored.
  logic unused_s;
  assign unused_s = ^{cpu_dbo, STAT_BASE};

  // Raw per-slave base/mask window match.
  always_comb begin
    hitv_s = '0;
    for (int i = 0; i < NSLV; i++) begin
      hitv_s[i] = ((cpu_ab & SLV_MASK[16*i +: 16]) == SLV_BASE[16*i +: 16]);
    end
  end

`ifdef BUS_FAULT_EN
  assign stat_hit_s = (cpu_ab[15:2] == STAT_BASE[15:2]);
`else
  assign stat_hit_s = 1'b0;
`endif

  // Isolate the lowest set hit bit; the status window suppresses every slave.
  assign cs_s = stat_hit_s ? '0 : (hitv_s & ~(hitv_s - NSLV'(1)));

  // Wait count and read data of the selected slave (cs_s is one-hot or zero).
  always_comb begin
    k_s      = 4'd0;
    slv_rd_s = 8'h00;
    for (int i = 0; i < NSLV; i++) begin
      k_s      = k_s | ({4{cs_s[i]}} & SLV_WAIT[4*i +: 4]);
      slv_rd_s = slv_rd_s | ({8{cs_s[i]}} & slv_dout[8*i +: 8]);
    end
  end

  // A WAIT whose selection has changed is abandoned and evaluated as IDLE
  // in the same cycle, so a strobe to the new address is not lost.
  assign idle_eval_s = (state_q == ST_IDLE) || (cs_s != wsel_q);

  // Wait-state next-state logic and stall output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wsel_d  = wsel_q;
    ready_s = 1'b1;
    if (idle_eval_s) begin
      ready_s = (k_s == 4'd0);
      if (cpu_clken && (k_s != 4'd0)) begin
        state_d = ST_WAIT;
        cnt_d   = k_s - 4'd1;
        wsel_d  = cs_s;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        wsel_d  = '0;
      end
    end else begin
      ready_s = (cnt_q == 4'd0);
      if (cpu_clken && (cnt_q != 4'd0)) begin
        cnt_d = cnt_q - 4'd1;
      end else if (cpu_clken) begin
        state_d = ST_IDLE;
        wsel_d  = '0;
      end else begin
        state_d = state_q;
      end
    end
  end

  // Wait-state register, counter and the selection captured on WAIT entry.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wsel_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wsel_q  <= wsel_d;
    end
  end

  assign cpu_ready = ready_s;
  assign slv_cs    = cs_s;
  assign slv_we    = cs_s & {NSLV{cpu_we & ready_s}};
  assign slv_en    = cs_s & {NSLV{cpu_clken & ready_s}};

`ifdef BUS_FAULT_EN
  logic [7:0]  fcnt_q, fcnt_d;
  logic [15:0] faddr_q, faddr_d;
  logic        done_s;
  logic        flt_s;
  logic        clr_s;

  assign done_s = cpu_clken & ready_s;
  assign flt_s  = done_s & ~stat_hit_s & ~(|hitv_s);
  assign clr_s  = done_s & cpu_we & stat_hit_s & (cpu_ab[1:0] == 2'd0);

  // Fault counter and sticky first-fault address; a fault beats a clear.
  always_comb begin
    fcnt_d  = fcnt_q;
    faddr_d = faddr_q;
    if (flt_s) begin
      if (clr_s || (fcnt_q == 8'd0)) begin
        fcnt_d  = 8'd1;
        faddr_d = cpu_ab;
      end else begin
        fcnt_d  = (fcnt_q == 8'hFF) ? fcnt_q : (fcnt_q + 8'd1);
        faddr_d = faddr_q;
      end
    end else if (clr_s) begin
      fcnt_d  = 8'd0;
      faddr_d = 16'h0000;
    end else begin
      fcnt_d  = fcnt_q;
    end
  end

  // Fault status registers.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= 8'd0;
      faddr_q <= 16'h0000;
    end else begin
      fcnt_q  <= fcnt_d;
      faddr_q <= faddr_d;
    end
  end

  // Status window read decode.
  always_comb begin
    stat_rd_s = 8'h00;
    case (cpu_ab[1:0])
      2'd0:    stat_rd_s = fcnt_q;
      2'd1:    stat_rd_s = faddr_q[7:0];
      2'd2:    stat_rd_s = faddr_q[15:8];
      default: stat_rd_s = 8'h00;
    endcase
  end

  assign fault = (fcnt_q != 8'd0);
`else
  assign stat_rd_s = 8'h00;
  assign fault     = 1'b0;
`endif

  // Read-data multiplexer: status window, then selected slave, then fill.
  always_comb begin
    cpu_dbi = FILL;
    if (stat_hit_s) begin
      cpu_dbi = stat_rd_s;
    end else if (|cs_s) begin
      cpu_dbi = slv_rd_s;
    end else begin
      cpu_dbi = FILL;
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: self-checking bench for bus_fabric.
// dut   : default parameters.
// dut_w : slave 4 with 3 wait states and slave 5 widened to a catch-all
//         window (base/mask 0) so overlapping windows exercise priority.
`timescale 1ns/1ps
module tb_bus_fabric;

  logic        clk25 = 1'b0;
  logic        rst_n;
  logic        cpu_clken;
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_dbo;
  logic [47:0] slv_dout;

  logic [7:0]  d_dbi, w_dbi;
  logic        d_rdy, w_rdy, d_flt, w_flt;
  logic [5:0]  d_cs, d_we, d_en, w_cs, w_we, w_en;

  int vectors     = 0;
  int miscompares = 0;

  always #20 clk25 = ~clk25;

  bus_fabric dut (
    .clk25(clk25), .rst_n(rst_n), .cpu_clken(cpu_clken), .cpu_ab(cpu_ab),
    .cpu_we(cpu_we), .cpu_dbo(cpu_dbo), .cpu_dbi(d_dbi), .cpu_ready(d_rdy),
    .slv_cs(d_cs), .slv_we(d_we), .slv_en(d_en), .slv_dout(slv_dout), .fault(d_flt)
  );

  bus_fabric #(
    .SLV_BASE({16'h0000, 16'hE000, 16'hD012, 16'hD010, 16'hC000, 16'h0000}),
    .SLV_MASK({16'h0000, 16'hF000, 16'hFFFE, 16'hFFFE, 16'hFFFC, 16'hE000}),
    .SLV_WAIT({4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0})
  ) dut_w (
    .clk25(clk25), .rst_n(rst_n), .cpu_clken(cpu_clken), .cpu_ab(cpu_ab),
    .cpu_we(cpu_we), .cpu_dbo(cpu_dbo), .cpu_dbi(w_dbi), .cpu_ready(w_rdy),
    .slv_cs(w_cs), .slv_we(w_we), .slv_en(w_en), .slv_dout(slv_dout), .fault(w_flt)
  );

  typedef struct {
    string      nm;
    logic       w;
    logic [7:0] dbi;
    logic       rdy;
    logic [5:0] cs;
    logic [5:0] swe;
    logic [5:0] en;
    logic       flt;
  } exp_t;

  typedef struct {
    logic [15:0] ab;
    logic        we;
    logic [7:0]  dbo;
    logic        ck;
    logic [7:0]  dbi;
    logic [5:0]  cs;
    logic [5:0]  swe;
    logic [5:0]  en;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];

  task automatic step(input logic [15:0] ab, input logic we, input logic [7:0] dbo, input logic ck);
    @(posedge clk25); #1;
    cpu_ab = ab; cpu_we = we; cpu_dbo = dbo; cpu_clken = ck;
  endtask

  task automatic push(input string nm, input logic w, input logic [7:0] dbi, input logic rdy,
                      input logic [5:0] cs, input logic [5:0] swe, input logic [5:0] en, input logic flt);
    exp_t e;
    e.nm = nm; e.w = w; e.dbi = dbi; e.rdy = rdy; e.cs = cs; e.swe = swe; e.en = en; e.flt = flt;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [7:0] a_dbi;
    logic       a_rdy, a_flt;
    logic [5:0] a_cs, a_we, a_en;
    @(negedge clk25);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got no expected record, required one");
    end else begin
      e = sb.pop_front();
      if (e.w) begin
        a_dbi = w_dbi; a_rdy = w_rdy; a_cs = w_cs; a_we = w_we; a_en = w_en; a_flt = w_flt;
      end else begin
        a_dbi = d_dbi; a_rdy = d_rdy; a_cs = d_cs; a_we = d_we; a_en = d_en; a_flt = d_flt;
      end
      if ({a_dbi, a_rdy, a_cs, a_we, a_en, a_flt} !== {e.dbi, e.rdy, e.cs, e.swe, e.en, e.flt}) begin
        miscompares++;
        $display("FAIL %s: got dbi=%h rdy=%b cs=%b we=%b en=%b fault=%b, required dbi=%h rdy=%b cs=%b we=%b en=%b fault=%b",
                 e.nm, a_dbi, a_rdy, a_cs, a_we, a_en, a_flt, e.dbi, e.rdy, e.cs, e.swe, e.en, e.flt);
      end
    end
  endtask

  task automatic run(input string nm, input logic [15:0] ab, input logic we, input logic [7:0] dbo,
                     input logic ck, input logic w, input logic [7:0] dbi, input logic rdy,
                     input logic [5:0] cs, input logic [5:0] swe, input logic [5:0] en, input logic flt);
    step(ab, we, dbo, ck);
    push(nm, w, dbi, rdy, cs, swe, en, flt);
    check_out();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{16'h0000, 1'b0, 8'h00, 1'b1, 8'hA0, 6'b000001, 6'b000000, 6'b000001};
    tbl[1] = '{16'h1FFF, 1'b1, 8'h3C, 1'b1, 8'hA0, 6'b000001, 6'b000001, 6'b000001};
    tbl[2] = '{16'h2000, 1'b0, 8'h00, 1'b0, 8'hFF, 6'b000000, 6'b000000, 6'b000000};
    tbl[3] = '{16'hC002, 1'b0, 8'h00, 1'b1, 8'hA1, 6'b000010, 6'b000000, 6'b000010};
    tbl[4] = '{16'hC004, 1'b1, 8'h11, 1'b0, 8'hFF, 6'b000000, 6'b000000, 6'b000000};
    tbl[5] = '{16'hD011, 1'b1, 8'h22, 1'b1, 8'hA2, 6'b000100, 6'b000100, 6'b000100};
    tbl[6] = '{16'hD013, 1'b0, 8'h00, 1'b1, 8'hA3, 6'b001000, 6'b000000, 6'b001000};
    tbl[7] = '{16'hFF80, 1'b0, 8'h00, 1'b1, 8'hA5, 6'b100000, 6'b000000, 6'b100000};
    tbl[8] = '{16'hFFFF, 1'b1, 8'h44, 1'b0, 8'hA5, 6'b100000, 6'b100000, 6'b000000};
    tbl[9] = '{16'hD00F, 1'b0, 8'h00, 1'b0, 8'hFF, 6'b000000, 6'b000000, 6'b000000};

    slv_dout  = {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rst_n     = 1'b0;
    cpu_clken = 1'b0;
    cpu_ab    = 16'h0000;
    cpu_we    = 1'b0;
    cpu_dbo   = 8'h00;
    repeat (3) @(posedge clk25);
    #1 rst_n = 1'b1;

    // Reset state
    run("reset_idle", 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA0, 1'b1, 6'b000001, 6'b000000, 6'b000000, 1'b0);
`ifdef BUS_FAULT_EN
    run("reset_stat0", 16'hC010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 6'b000000, 6'b000000, 6'b000000, 1'b0);
`else
    run("reset_stat0", 16'hC010, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 6'b000000, 6'b000000, 6'b000000, 1'b0);
`endif

    // Zero-wait decode table
    for (int i = 0; i < 10; i++) begin
      run($sformatf("tbl%0d", i), tbl[i].ab, tbl[i].we, tbl[i].dbo, tbl[i].ck, 1'b0,
          tbl[i].dbi, 1'b1, tbl[i].cs, tbl[i].swe, tbl[i].en, 1'b0);
    end

    // Basic one-wait hit on slave 4
    run("hit_stall",  16'hE123, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA4, 1'b0, 6'b010000, 6'b000000, 6'b000000, 1'b0);
    run("hit_done",   16'hE123, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA4, 1'b1, 6'b010000, 6'b000000, 6'b010000, 1'b0);

    // Leaving a pending wait without a strobe abandons it
    run("abandon_idle", 16'h0010, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA0, 1'b1, 6'b000001, 6'b000000, 6'b000000, 1'b0);
    // Abandon after one stalled strobe on the 3-wait slave
    run("abandon_enter", 16'hE123, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b0, 6'b010000, 6'b000000, 6'b000000, 1'b0);
    run("abandon_new",   16'h0010, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA0, 1'b1, 6'b000001, 6'b000000, 6'b000001, 1'b0);

    // Overlapping windows: lowest index wins
    run("prio_only5", 16'h9000, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 6'b100000, 6'b000000, 6'b000000, 1'b0);
    run("prio_0over5", 16'h0010, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA0, 1'b1, 6'b000001, 6'b000000, 6'b000000, 1'b0);

    // Exactly three stalled strobes, completion on the fourth
    for (int n = 0; n < 3; n++) begin
      run($sformatf("wait3_stall%0d", n), 16'hE123, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b0,
          6'b010000, 6'b000000, 6'b000000, 1'b0);
    end
    run("wait3_done", 16'hE123, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b1, 6'b010000, 6'b000000, 6'b010000, 1'b0);

    // Reset mid-WAIT restarts the full wait count
    run("rstwait_enter", 16'hE123, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b0, 6'b010000, 6'b000000, 6'b000000, 1'b0);
    step(16'hE123, 1'b0, 8'h00, 1'b0);
    #5 rst_n = 1'b0;
    #5 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      run($sformatf("rstwait_stall%0d", n), 16'hE123, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b0,
          6'b010000, 6'b000000, 6'b000000, 1'b0);
    end
    run("rstwait_done", 16'hE123, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b1, 6'b010000, 6'b000000, 6'b010000, 1'b0);

`ifdef BUS_FAULT_EN
    // Unmapped read and status window contents
    run("unm_rd",  16'h9000, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 6'b0, 6'b0, 6'b0, 1'b0);
    run("unm_cnt", 16'hC010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
    run("unm_lo",  16'hC011, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
    run("unm_hi",  16'hC012, 1'b0, 8'h00, 1'b0, 1'b0, 8'h90, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
    run("unm_p3",  16'hC013, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);

    // Clear, then 300 faults: sticky first address, saturating count
    run("clr_wr",    16'hC010, 1'b1, 8'h55, 1'b1, 1'b0, 8'h01, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
    run("sat_first", 16'hA55A, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 6'b0, 6'b0, 6'b0, 1'b0);
    for (int n = 0; n < 299; n++) step(16'hB000, 1'b0, 8'h00, 1'b1);
    run("sat_cnt", 16'hC010, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
    run("sat_lo",  16'hC011, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
    run("sat_hi",  16'hC012, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);

    // Clear from a second master on the same strobe as a fault at 8001
    step(16'h8001, 1'b1, 8'h00, 1'b1);
    force dut.clr_s = 1'b1;
    @(posedge clk25); #1;
    release dut.clr_s;
    cpu_ab = 16'hC010; cpu_we = 1'b0; cpu_clken = 1'b0;
    push("clrflt_cnt", 1'b0, 8'h01, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
    check_out();
    run("clrflt_lo", 16'hC011, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
    run("clrflt_hi", 16'hC012, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);

    // Unmapped write: no slave strobe, counts as a fault, address stays sticky
    run("unm_wr",     16'h9000, 1'b1, 8'h5A, 1'b1, 1'b0, 8'hFF, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
    run("unm_wr_cnt", 16'hC010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
    run("unm_wr_hi",  16'hC012, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 1'b1, 6'b0, 6'b0, 6'b0, 1'b1);
`else
    // Fault logic absent: status window is unmapped and fault stays low
    run("nf_rd",     16'h9000, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 6'b0, 6'b0, 6'b0, 1'b0);
    run("nf_stat",   16'hC010, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 6'b0, 6'b0, 6'b0, 1'b0);
    run("nf_wr",     16'h9000, 1'b1, 8'h5A, 1'b1, 1'b0, 8'hFF, 1'b1, 6'b0, 6'b0, 6'b0, 1'b0);
    run("nf_statwr", 16'hC010, 1'b1, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 6'b0, 6'b0, 6'b0, 1'b0);
    run("nf_stat1",  16'hC011, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 6'b0, 6'b0, 6'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
